// File: rtl/ud_bitstream_gen.sv
// First-order delta-sigma encoder: offset-binary code -> (u_d, en) stream for an up/down counter.
// Optional build macro SDM_DITHER_EN seeds the accumulator from a 16-bit LFSR at frame start.
module ud_bitstream_gen #(
  parameter int WIDTH      = 16,
  parameter int FRAME_LOG2 = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             hold,
  output logic             u_d,
  output logic             en,
  output logic             frame_done,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q;
  logic [WIDTH-1:0]      code_q;
  logic [WIDTH-1:0]      shadow_q;
  logic                  shadow_valid_q;
  logic [WIDTH-1:0]      acc_q;
  logic [FRAME_LOG2-1:0] fcnt_q;
  logic                  u_d_q;
  logic                  en_q;
  logic                  frame_done_q;

  logic [WIDTH:0]        sum_d;
  logic [WIDTH-1:0]      seed_d;
  logic                  take_d;
  logic                  frame_end_d;

  assign sum_d       = {1'b0, acc_q} + {1'b0, code_q};
  assign take_d      = in_valid && in_ready;
  assign frame_end_d = (fcnt_q == '1);

`ifdef SDM_DITHER_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; free-running every clock
  always_ff @(posedge clk) begin
    if (!rstb) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign seed_d = lfsr_q[WIDTH-1:0];
`else
  assign seed_d = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q        <= IDLE;
      code_q         <= '0;
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
      acc_q          <= '0;
      fcnt_q         <= '0;
      u_d_q          <= 1'b0;
      en_q           <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (take_d) begin
        shadow_q       <= in_data;
        shadow_valid_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          en_q <= 1'b0;
          if (shadow_valid_q) begin
            code_q         <= shadow_q;
            shadow_valid_q <= 1'b0;
            acc_q          <= seed_d;
            fcnt_q         <= '0;
            state_q        <= RUN;
          end
        end
        RUN: begin
          if (hold) begin
            en_q <= 1'b0;
          end else begin
            u_d_q  <= sum_d[WIDTH];
            acc_q  <= sum_d[WIDTH-1:0];
            en_q   <= 1'b1;
            fcnt_q <= fcnt_q + 1'b1;
            if (frame_end_d) begin
              frame_done_q <= 1'b1;
              // Next code is chained with acc kept; a same-cycle offer bypasses the empty shadow
              if (shadow_valid_q) begin
                code_q         <= shadow_q;
                shadow_valid_q <= 1'b0;
              end else if (in_valid) begin
                code_q         <= in_data;
                shadow_valid_q <= 1'b0;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = !shadow_valid_q;
  assign u_d        = u_d_q;
  assign en         = en_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_ud_bitstream_gen.sv
// Scoreboard bench for ud_bitstream_gen: accepted codes are queued, a negedge monitor
// regenerates each frame's bits from the accumulate-and-carry rule and compares.
module tb_ud_bitstream_gen;

  localparam int W    = 16;
  localparam int FL   = 8;
  localparam int FLEN = 1 << FL;

  logic         clk = 1'b0;
  logic         rstb;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         hold;
  logic         u_d;
  logic         en;
  logic         frame_done;
  logic         busy;

  always #5 clk = ~clk;

  ud_bitstream_gen #(.WIDTH(W), .FRAME_LOG2(FL)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .hold       (hold),
    .u_d        (u_d),
    .en         (en),
    .frame_done (frame_done),
    .busy       (busy)
  );

  // accepted-code queue (driver writes, monitor reads)
  logic [W-1:0] code_q [0:1023];
  int unsigned  code_wr = 0;
  int unsigned  code_rd = 0;

  // directed-check requests (driver writes, monitor compares)
  string        ck_nm  [0:255];
  logic [31:0]  ck_act [0:255];
  logic [31:0]  ck_exp [0:255];
  int unsigned  ck_wr = 0;
  int unsigned  ck_rd = 0;

  int compared   = 0;
  int mismatched = 0;

  // input values seen by the DUT at the latest edge
  logic hold_e = 1'b0;
  logic rst_e  = 1'b0;
  always @(posedge clk) begin
    hold_e = hold;
    rst_e  = !rstb;
  end

  // reference model state
  logic [W-1:0] acc_m = '0;
  logic [W-1:0] cur_m = '0;
  logic [W:0]   s_m;
  logic         exp_bit;
  bit           in_frame    = 0;
  bit           carry_acc   = 0;
  bit           expect_next = 0;
  int           bitpos      = 0;
  int           ones        = 0;
  int           gaps        = 0;
  int           last_ones   = 0;
  int           last_gaps   = 0;
  int           frames_done = 0;
  int           cnt_m       = 32'h8000;

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_e) begin
      code_rd     = code_wr;
      in_frame    = 0;
      carry_acc   = 0;
      expect_next = 0;
    end else begin
      if (expect_next) begin
        if (en) expect_next = 0;
        else if (!hold_e) begin
          cmp("b2b_gap_en", {31'd0, en}, 32'd1);
          expect_next = 0;
        end
      end
      if (en) begin
        if (!in_frame) begin
          if (code_rd == code_wr) begin
            cmp("bit_without_code", 32'd1, 32'd0);
          end else begin
            cur_m = code_q[code_rd % 1024];
            code_rd++;
          end
          if (!carry_acc) acc_m = '0;
          bitpos   = 0;
          ones     = 0;
          gaps     = 0;
          in_frame = 1;
        end
        s_m     = {1'b0, acc_m} + {1'b0, cur_m};
        exp_bit = s_m[W];
        acc_m   = s_m[W-1:0];
        cmp("u_d", {31'd0, u_d}, {31'd0, exp_bit});
        bitpos++;
        ones += int'(exp_bit);
        cmp("frame_done", {31'd0, frame_done}, (bitpos == FLEN) ? 32'd1 : 32'd0);
        cnt_m += u_d ? 1 : -1;
        if (bitpos == FLEN) begin
          in_frame    = 0;
          carry_acc   = (code_rd != code_wr);
          expect_next = carry_acc;
          last_ones   = ones;
          last_gaps   = gaps;
          frames_done++;
        end
      end else begin
        cmp("frame_done_idle", {31'd0, frame_done}, 32'd0);
        if (in_frame) begin
          gaps++;
          if (!hold_e) cmp("mid_frame_en", {31'd0, en}, 32'd1);
        end
      end
    end
    while (ck_rd != ck_wr) begin
      cmp(ck_nm[ck_rd % 256], ck_act[ck_rd % 256], ck_exp[ck_rd % 256]);
      ck_rd++;
    end
  end

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    ck_nm[ck_wr % 256]  = nm;
    ck_act[ck_wr % 256] = a;
    ck_exp[ck_wr % 256] = e;
    ck_wr++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] c);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = c;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(posedge clk);
      if (in_ready) begin
        code_q[code_wr % 1024] = c;
        code_wr++;
        ok = 1;
      end
    end
    #1;
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      #1;
      if (!busy && code_rd == code_wr && !in_frame) done = 1;
    end
    if (!done) check({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_frame(input logic [W-1:0] c, input int exp_ones, input logic [15:0] exp_cnt,
                           input string nm);
    int start;
    logic [15:0] fin;
    start = cnt_m;
    send(c);
    wait_idle(nm);
    fin = 16'(32'h8000 + cnt_m - start);
    check({nm, "_ones"}, last_ones, exp_ones);
    check({nm, "_counter"}, {16'd0, fin}, {16'd0, exp_cnt});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b, c;
    int f0;
    rstb     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    hold     = 1'b0;
    repeat (3) tick();
    check("rst_u_d", {31'd0, u_d}, 32'd0);
    check("rst_en", {31'd0, en}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rstb = 1'b1;
    tick();

    run_frame(16'h8000, 128, 16'h8000, "mid");
    run_frame(16'hC000, 192, 16'h8080, "c000");
    run_frame(16'h0000, 0,   16'h7F00, "zero");
    run_frame(16'hFFFF, 255, 16'h80FE, "full");

    // back-to-back: second code fills the shadow, third stalls until frame end
    a = W'($urandom);
    b = W'($urandom);
    c = W'($urandom);
    f0 = frames_done;
    send(a);
    repeat (50) tick();
    send(b);
    in_valid = 1'b1;
    in_data  = c;
    repeat (20) tick();
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    send(c);
    wait_idle("b2b");
    check("b2b_frames", frames_done - f0, 32'd3);

    // hold pulse mid-frame
    a = W'($urandom);
    send(a);
    repeat (60) tick();
    hold = 1'b1;
    repeat (10) tick();
    hold = 1'b0;
    wait_idle("hold");
    check("hold_gaps", last_gaps, 32'd10);
    check("hold_ones", last_ones, {24'd0, a[15:8]});

    // bypass: offer lands exactly on the last-bit edge
    a = W'($urandom);
    b = W'($urandom);
    send(a);
    repeat (256) tick();
    send(b);
    check("bypass_busy", {31'd0, busy}, 32'd1);
    check("bypass_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bypass_next_en", {31'd0, en}, 32'd1);
    wait_idle("bypass");

    // reset at bit ~100 aborts the frame
    send(16'h5A5A);
    repeat (100) tick();
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    check("abort_en", {31'd0, en}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_u_d", {31'd0, u_d}, 32'd0);
    tick();
    check("abort_en_next", {31'd0, en}, 32'd0);
    run_frame(16'h8000, 128, 16'h8000, "post_abort");

    // randomized codes, gaps and hold activity
    for (int k = 0; k < 12; k++) begin
      send(W'($urandom));
      for (int j = 0; j < int'($urandom_range(0, 300)); j++) begin
        hold = ($urandom_range(0, 7) == 0);
        tick();
      end
      hold = 1'b0;
    end
    wait_idle("random");

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
